// File: rtl/ram8_arbiter.sv
// Round-robin arbiter and sequencer sharing one ram8 between two ports.
// One full read or write per grant; registered ram output adds a READ cycle.
module ram8_arbiter #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_p0,
   input  logic              we_p0,
   input  logic [ADDR_W-1:0] addr_p0,
   input  logic [DATA_W-1:0] wdata_p0,
   output logic              ack_p0,
   output logic [DATA_W-1:0] rdata_p0,
   input  logic              req_p1,
   input  logic              we_p1,
   input  logic [ADDR_W-1:0] addr_p1,
   input  logic [DATA_W-1:0] wdata_p1,
   output logic              ack_p1,
   output logic [DATA_W-1:0] rdata_p1,
   output logic [DATA_W-1:0] mem_in,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_load,
   input  logic [DATA_W-1:0] mem_out,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      READ,
      RESP
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic              last_grant;
   logic              grant_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              grant;
   logic              take;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // on a tie the port that did not win last time gets the grant
   always_comb begin
      state_nx = state;
      grant    = 1'b0;
      take     = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_p0 && req_p1) begin
               grant = ~last_grant;
               take  = 1'b1;
            end else if (req_p0) begin
               grant = 1'b0;
               take  = 1'b1;
            end else if (req_p1) begin
               grant = 1'b1;
               take  = 1'b1;
            end
            if (take) begin
               state_nx = ACCESS;
            end
         end
         ACCESS: state_nx = we_q ? RESP : READ;
         READ:   state_nx = RESP;
         RESP:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= 1'b1;
         grant_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else if (take) begin
         last_grant <= grant;
         grant_q    <= grant;
         we_q       <= grant ? we_p1 : we_p0;
         addr_q     <= grant ? addr_p1 : addr_p0;
         wdata_q    <= grant ? wdata_p1 : wdata_p0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_p0 <= '0;
         rdata_p1 <= '0;
      end else if (state == READ) begin
         if (grant_q) begin
            rdata_p1 <= mem_out;
         end else begin
            rdata_p0 <= mem_out;
         end
      end
   end

   // decoded from state so reset removes the write strobe immediately
   assign mem_load    = (state == ACCESS) && we_q;
   assign mem_address = addr_q;
   assign mem_in      = wdata_q;
   assign ack_p0      = (state == RESP) && !grant_q;
   assign ack_p1      = (state == RESP) && grant_q;
   assign busy        = (state != IDLE);

endmodule
